aline_acquisition_ctrl: RTL and testbench

//  Sequences digitizer capture per swept-source sweep trigger: per A-line, NSAMPLES

---
 rtl/aline_acquisition_ctrl_pkg.sv | 22 ++
 rtl/aline_acquisition_ctrl_if.sv | 46 ++++
 rtl/aline_acquisition_ctrl_trig_edge_detect.sv | 26 ++
 rtl/aline_acquisition_ctrl.sv | 161 ++++++++++++++++
 tb/tb_aline_acquisition_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/aline_acquisition_ctrl_pkg.sv
// Shared definitions for the A-line acquisition controller: FSM encoding,
// field widths and default geometry for one swept-source B-scan.
package aline_acquisition_ctrl_pkg;

  localparam int ADDR_W  = 11;
  localparam int ALINE_W = 10;
  localparam int DLY_W   = 8;
  localparam int MISS_W  = 8;

  localparam int unsigned DEF_NSAMPLES = 1170;
  localparam int unsigned DEF_NALINES  = 512;
  localparam int unsigned DEF_TRIG_DLY = 0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARMED   = 3'd1;
  localparam state_t ST_DELAY   = 3'd2;
  localparam state_t ST_CAPTURE = 3'd3;
  localparam state_t ST_CLOSE   = 3'd4;

endpackage

// File: rtl/aline_acquisition_ctrl_if.sv
// Run-control, trigger, buffer-write and readout-handshake signals of the
// acquisition controller; master is the controller, slave is the host side.
interface aline_acquisition_ctrl_if;
  import aline_acquisition_ctrl_pkg::*;

  logic               enable;
  logic               sweep_trig;
  logic [1:0]         rd_release;
  logic [ADDR_W-1:0]  wr_addr;
  logic               wr_en;
  logic               wr_bank;
  logic [ALINE_W-1:0] aline_idx;
  logic               aline_done;
  logic [1:0]         bank_ready;
  logic               overrun;
  logic [MISS_W-1:0]  trig_missed;

  modport master (
    input  enable,
    input  sweep_trig,
    input  rd_release,
    output wr_addr,
    output wr_en,
    output wr_bank,
    output aline_idx,
    output aline_done,
    output bank_ready,
    output overrun,
    output trig_missed
  );

  modport slave (
    output enable,
    output sweep_trig,
    output rd_release,
    input  wr_addr,
    input  wr_en,
    input  wr_bank,
    input  aline_idx,
    input  aline_done,
    input  bank_ready,
    input  overrun,
    input  trig_missed
  );

endinterface

// File: rtl/aline_acquisition_ctrl_trig_edge_detect.sv
// Rising-edge detector for a trigger level already synchronous to clock;
// the edge is combinational on the current level against the registered one.
module aline_acquisition_ctrl_trig_edge_detect (
  input  logic clock,
  input  logic sclr,
  input  logic trig_in,
  output logic trig_edge
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d    = trig_in;
    trig_edge = trig_in & ~prev_q;
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/aline_acquisition_ctrl.sv
// Per-sweep capture sequencer: writes NSAMPLES addresses per A-line into a
// ping-pong B-scan buffer and hands full banks to readout.
module aline_acquisition_ctrl
  import aline_acquisition_ctrl_pkg::*;
#(
  parameter int unsigned NSAMPLES = DEF_NSAMPLES,
  parameter int unsigned NALINES  = DEF_NALINES,
  parameter int unsigned TRIG_DLY = DEF_TRIG_DLY
) (
  input  logic                    clock,
  input  logic                    sclr,
  aline_acquisition_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NSAMPLES - 1);
  localparam logic [ALINE_W-1:0] LAST_ALINE = ALINE_W'(NALINES - 1);
  localparam logic [DLY_W-1:0]   DLY_LOAD   = DLY_W'(TRIG_DLY - 1);

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic trig_edge;

  aline_acquisition_ctrl_trig_edge_detect u_trig_edge (
    .clock     (clock),
    .sclr      (sclr),
    .trig_in   (bus.sweep_trig),
    .trig_edge (trig_edge)
  );

  state_t             state_q,       state_d;
  logic [DLY_W-1:0]   dly_cnt_q,     dly_cnt_d;
  logic [ADDR_W-1:0]  wr_addr_q,     wr_addr_d;
  logic               wr_en_q,       wr_en_d;
  logic               wr_bank_q,     wr_bank_d;
  logic [ALINE_W-1:0] aline_idx_q,   aline_idx_d;
  logic               aline_done_q,  aline_done_d;
  logic [1:0]         bank_ready_q,  bank_ready_d;
  logic               overrun_q,     overrun_d;
  logic [MISS_W-1:0]  trig_missed_q, trig_missed_d;

  always_comb begin
    state_d       = state_q;
    dly_cnt_d     = dly_cnt_q;
    wr_addr_d     = wr_addr_q;
    wr_en_d       = wr_en_q;
    wr_bank_d     = wr_bank_q;
    aline_idx_d   = aline_idx_q;
    aline_done_d  = 1'b0;
    overrun_d     = overrun_q;
    trig_missed_d = trig_missed_q;
    // Releases always apply; a bank being closed this cycle is OR-ed in below.
    bank_ready_d  = bank_ready_q & ~bus.rd_release;

    // Any edge outside ARMED/IDLE cannot start an A-line and is only counted.
    if (trig_edge && (state_q == ST_DELAY || state_q == ST_CAPTURE ||
                      state_q == ST_CLOSE)) begin
      trig_missed_d = sat_inc(trig_missed_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (trig_edge) begin
          if (bank_ready_q[wr_bank_q]) begin
            overrun_d = 1'b1;
          end else if (TRIG_DLY != 0) begin
            state_d   = ST_DELAY;
            dly_cnt_d = DLY_LOAD;
          end else begin
            state_d   = ST_CAPTURE;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
          end
        end
      end

      ST_DELAY: begin
        if (dly_cnt_q == '0) begin
          state_d   = ST_CAPTURE;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q - 1'b1;
        end
      end

      ST_CAPTURE: begin
        if (wr_addr_q == LAST_ADDR) begin
          // Bookkeeping lands together with aline_done in the CLOSE cycle.
          state_d      = ST_CLOSE;
          wr_en_d      = 1'b0;
          wr_addr_d    = '0;
          aline_done_d = 1'b1;
          if (aline_idx_q == LAST_ALINE) begin
            aline_idx_d             = '0;
            bank_ready_d[wr_bank_q] = 1'b1;
            wr_bank_d               = ~wr_bank_q;
          end else begin
            aline_idx_d = aline_idx_q + 1'b1;
          end
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end

      ST_CLOSE: begin
        state_d = bus.enable ? ST_ARMED : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q       <= ST_IDLE;
      dly_cnt_q     <= '0;
      wr_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      aline_idx_q   <= '0;
      aline_done_q  <= 1'b0;
      bank_ready_q  <= '0;
      overrun_q     <= 1'b0;
      trig_missed_q <= '0;
    end else begin
      state_q       <= state_d;
      dly_cnt_q     <= dly_cnt_d;
      wr_addr_q     <= wr_addr_d;
      wr_en_q       <= wr_en_d;
      wr_bank_q     <= wr_bank_d;
      aline_idx_q   <= aline_idx_d;
      aline_done_q  <= aline_done_d;
      bank_ready_q  <= bank_ready_d;
      overrun_q     <= overrun_d;
      trig_missed_q <= trig_missed_d;
    end
  end

  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.aline_idx   = aline_idx_q;
  assign bus.aline_done  = aline_done_q;
  assign bus.bank_ready  = bank_ready_q;
  assign bus.overrun     = overrun_q;
  assign bus.trig_missed = trig_missed_q;

endmodule

// File: tb/tb_aline_acquisition_ctrl.sv
// Directed bench for the acquisition controller: an 8-sample/2-A-line instance
// with no trigger delay and a second instance with a 3-clock trigger delay.
module tb_aline_acquisition_ctrl;

  logic clock = 1'b0;
  logic sclr  = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  aline_acquisition_ctrl_if ifa ();
  aline_acquisition_ctrl_if ifb ();

  aline_acquisition_ctrl #(.NSAMPLES(8), .NALINES(2), .TRIG_DLY(0)) u_dut_a (
    .clock (clock),
    .sclr  (sclr),
    .bus   (ifa)
  );

  aline_acquisition_ctrl #(.NSAMPLES(8), .NALINES(2), .TRIG_DLY(3)) u_dut_b (
    .clock (clock),
    .sclr  (sclr),
    .bus   (ifb)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full A-line on DUT a from an edge in the current cycle.
  // mode 0: plain; mode 1: three extra edges during capture; mode 2: enable drops at addr 3.
  task automatic run_aline(input string tag, input int mode, input logic [9:0] exp_idx,
                           input logic exp_bank, input logic [1:0] exp_ready);
    ifa.sweep_trig = 1'b1;
    step();
    ifa.sweep_trig = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq({tag, "_wr_en"}, 32'(ifa.wr_en), 32'd1);
      check_eq({tag, "_wr_addr"}, 32'(ifa.wr_addr), 32'(i));
      if (mode == 1) ifa.sweep_trig = (i == 1 || i == 3 || i == 5);
      if (mode == 2 && i == 3) ifa.enable = 1'b0;
      step();
    end
    ifa.sweep_trig = 1'b0;
    check_eq({tag, "_close_wr_en"}, 32'(ifa.wr_en), 32'd0);
    check_eq({tag, "_close_addr"}, 32'(ifa.wr_addr), 32'd0);
    check_eq({tag, "_aline_done"}, 32'(ifa.aline_done), 32'd1);
    check_eq({tag, "_aline_idx"}, 32'(ifa.aline_idx), 32'(exp_idx));
    check_eq({tag, "_wr_bank"}, 32'(ifa.wr_bank), 32'(exp_bank));
    check_eq({tag, "_bank_ready"}, 32'(ifa.bank_ready), 32'(exp_ready));
    step();
    check_eq({tag, "_done_pulse"}, 32'(ifa.aline_done), 32'd0);
  endtask

  task automatic release_bank(input logic [1:0] rel);
    ifa.rd_release = rel;
    step();
    ifa.rd_release = 2'b00;
  endtask

  initial begin
    ifa.enable = 1'b0; ifa.sweep_trig = 1'b0; ifa.rd_release = 2'b00;
    ifb.enable = 1'b0; ifb.sweep_trig = 1'b0; ifb.rd_release = 2'b00;

    // Reset state
    step(); step();
    check_eq("rst_wr_en", 32'(ifa.wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(ifa.wr_addr), 32'd0);
    check_eq("rst_bank_ready", 32'(ifa.bank_ready), 32'd0);
    check_eq("rst_overrun", 32'(ifa.overrun), 32'd0);
    check_eq("rst_trig_missed", 32'(ifa.trig_missed), 32'd0);
    check_eq("rst_aline_done", 32'(ifa.aline_done), 32'd0);
    sclr = 1'b0;
    ifa.enable = 1'b1;
    step();

    // First A-line timing, second A-line fills bank 0
    run_aline("al1", 0, 10'd1, 1'b0, 2'b00);
    run_aline("al2", 0, 10'd0, 1'b1, 2'b01);
    release_bank(2'b01);
    check_eq("rel0_bank_ready", 32'(ifa.bank_ready), 32'd0);

    // Fill both banks with no release, then an overrun edge
    run_aline("al3", 0, 10'd1, 1'b1, 2'b00);
    run_aline("al4", 0, 10'd0, 1'b0, 2'b10);
    run_aline("al5", 0, 10'd1, 1'b0, 2'b10);
    run_aline("al6", 0, 10'd0, 1'b1, 2'b11);
    ifa.sweep_trig = 1'b1;
    step();
    ifa.sweep_trig = 1'b0;
    check_eq("ovr_overrun", 32'(ifa.overrun), 32'd1);
    check_eq("ovr_wr_en", 32'(ifa.wr_en), 32'd0);
    step();
    check_eq("ovr_wr_en_hold", 32'(ifa.wr_en), 32'd0);
    check_eq("ovr_missed", 32'(ifa.trig_missed), 32'd0);
    release_bank(2'b10);
    check_eq("rel1_bank_ready", 32'(ifa.bank_ready), 32'd1);

    // Extra edges during capture are counted, capture unaffected
    run_aline("al7", 1, 10'd1, 1'b1, 2'b01);
    check_eq("miss_count", 32'(ifa.trig_missed), 32'd3);
    check_eq("miss_overrun_sticky", 32'(ifa.overrun), 32'd1);
    release_bank(2'b01);
    check_eq("rel0b_bank_ready", 32'(ifa.bank_ready), 32'd0);

    // enable drops mid A-line: completes, then IDLE ignores edges
    run_aline("al8", 2, 10'd0, 1'b0, 2'b10);
    ifa.sweep_trig = 1'b1;
    step();
    ifa.sweep_trig = 1'b0;
    check_eq("idle_wr_en", 32'(ifa.wr_en), 32'd0);
    step();
    check_eq("idle_wr_en2", 32'(ifa.wr_en), 32'd0);
    check_eq("idle_missed", 32'(ifa.trig_missed), 32'd3);
    ifa.enable = 1'b1;
    step();
    run_aline("al9", 0, 10'd1, 1'b0, 2'b10);

    // sclr mid-capture aborts at addr 5
    ifa.sweep_trig = 1'b1;
    step();
    ifa.sweep_trig = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("abort_addr", 32'(ifa.wr_addr), 32'(i));
      if (i < 5) step();
    end
    sclr = 1'b1;
    ifa.enable = 1'b0;
    step();
    check_eq("abort_wr_en", 32'(ifa.wr_en), 32'd0);
    check_eq("abort_wr_addr", 32'(ifa.wr_addr), 32'd0);
    check_eq("abort_aline_done", 32'(ifa.aline_done), 32'd0);
    check_eq("abort_aline_idx", 32'(ifa.aline_idx), 32'd0);
    check_eq("abort_bank_ready", 32'(ifa.bank_ready), 32'd0);
    check_eq("abort_overrun", 32'(ifa.overrun), 32'd0);
    check_eq("abort_missed", 32'(ifa.trig_missed), 32'd0);
    sclr = 1'b0;
    step();
    check_eq("abort_no_done", 32'(ifa.aline_done), 32'd0);

    // Trigger delay of 3 clocks: first write at T+4
    ifb.enable = 1'b1;
    step();
    ifb.sweep_trig = 1'b1;
    step();
    ifb.sweep_trig = 1'b0;
    check_eq("dly_t1_wr_en", 32'(ifb.wr_en), 32'd0);
    step();
    check_eq("dly_t2_wr_en", 32'(ifb.wr_en), 32'd0);
    step();
    check_eq("dly_t3_wr_en", 32'(ifb.wr_en), 32'd0);
    step();
    check_eq("dly_t4_wr_en", 32'(ifb.wr_en), 32'd1);
    check_eq("dly_t4_addr", 32'(ifb.wr_addr), 32'd0);
    step();
    check_eq("dly_t5_addr", 32'(ifb.wr_addr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
